// File: rtl/trans_pkg.sv
// Shared constants and FSM encoding for the transpose writer/reader pair.
// Both sides of the 512-bit result buffer derive their geometry from here.
package trans_pkg;

    localparam int M_ROW  = 64;
    localparam int M_COW  = 64;
    localparam int DW     = 64;
    localparam int LANES  = 8;

    localparam int NE     = M_ROW * M_COW;
    localparam int NW     = NE / LANES;
    localparam int AW     = $clog2(NW);
    localparam int LANE_W = $clog2(LANES);
    localparam int ELEM_W = $clog2(NE);
    localparam int COL_W  = $clog2(M_ROW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } trans_state_e;

endpackage

// File: rtl/trans_word_fifo.sv
// Two-entry word FIFO between the buffer read port and the lane unpacker.
// A push in the same cycle as a pop is accepted even when the FIFO is full.
module trans_word_fifo
    import trans_pkg::*;
#(
    parameter int WIDTH = LANES * DW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register in this block sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/trans_reader.sv
// Streams the transpose result buffer back out as one DW-bit element per handshake,
// prefetching at most two words ahead of the lane unpacker.
module trans_reader
    import trans_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [AW-1:0]         raddr,
    input  logic [LANES*DW-1:0]   rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DW-1:0]         m_data,
    output logic                  m_last,
    output logic                  m_eot
);

    trans_state_e              state;
    trans_state_e              state_nxt;

    logic [AW:0]               rd_cnt;
    logic [1:0]                inflight;
    logic [RD_LAT-1:0]         rd_pipe;
    logic [LANE_W-1:0]         lane_cnt;
    logic [ELEM_W-1:0]         elem_cnt;
    logic [COL_W-1:0]          col_cnt;

    logic                      start_ok;
    logic                      push;
    logic                      pop;
    logic                      xfer;
    logic                      last_read;
    logic [1:0]                fifo_count;
    logic [LANES*DW-1:0]       fifo_rdata;
    logic [LANES-1:0][DW-1:0]  head;
    logic [2:0]                words_ahead;

    assign start_ok    = (state == ST_IDLE) && start;
    assign push        = rd_pipe[RD_LAT-1];
    assign xfer        = m_valid && m_ready;
    assign pop         = xfer && (lane_cnt == LANE_W'(LANES - 1));
    assign words_ahead = {1'b0, fifo_count} + {1'b0, inflight};
    assign last_read   = rd_en && (rd_cnt == (AW + 1)'(NW - 1));
    assign raddr       = rd_cnt[AW-1:0];

    // The FIFO head is the word being unpacked, so the element is valid as soon
    // as a word lands and the next word is already in place at lane LANES-1.
    assign head     = fifo_rdata;
    assign m_valid  = (fifo_count != 2'd0);
    assign m_data   = m_valid ? head[lane_cnt] : '0;
    assign m_last   = m_valid && (col_cnt == COL_W'(M_ROW - 1));
    assign m_eot    = m_valid && (elem_cnt == ELEM_W'(NE - 1));

    trans_word_fifo #(
        .WIDTH (LANES * DW)
    ) u_word_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (rd_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)        state_nxt = ST_RUN;
            ST_RUN:   if (last_read)    state_nxt = ST_DRAIN;
            ST_DRAIN: if (xfer && m_eot) state_nxt = ST_DONE;
            ST_DONE:                    state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        rd_en = 1'b0;
        case (state)
            ST_RUN: begin
                busy  = 1'b1;
                rd_en = (words_ahead < 3'd2) && (rd_cnt < (AW + 1)'(NW));
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Read-latency shift register; clearing it on reset drops any data still
    // on its way back from the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 2'd0;
        end else begin
            case ({rd_en, push})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt   <= '0;
            lane_cnt <= '0;
            elem_cnt <= '0;
            col_cnt  <= '0;
        end else if (start_ok) begin
            rd_cnt   <= '0;
            lane_cnt <= '0;
            elem_cnt <= '0;
            col_cnt  <= '0;
        end else begin
            if (rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (xfer) begin
                lane_cnt <= (lane_cnt == LANE_W'(LANES - 1)) ? '0 : lane_cnt + 1'b1;
                col_cnt  <= (col_cnt == COL_W'(M_ROW - 1)) ? '0 : col_cnt + 1'b1;
                elem_cnt <= elem_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trans_reader.sv
// Directed bench for trans_reader: buffer model returns word w lane k = w*8+k,
// one DUT built with RD_LAT=1 for the main scenarios and one with RD_LAT=2.
module tb_trans_reader;

    localparam int TB_NE     = 4096;
    localparam int TB_MROW   = 64;
    localparam int TB_BUDGET = 20000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [8:0]    raddr;
    logic [511:0]  rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [63:0]   m_data;
    logic          m_last;
    logic          m_eot;

    logic          start2;
    logic          busy2;
    logic          done2;
    logic          rd_en2;
    logic [8:0]    raddr2;
    logic [511:0]  rd_data2;
    logic [511:0]  rd_stage2;
    logic          m_valid2;
    logic          m_ready2;
    logic [63:0]   m_data2;
    logic          m_last2;
    logic          m_eot2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trans_reader #(.RD_LAT(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .raddr   (raddr),
        .rd_data (rd_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_eot   (m_eot)
    );

    trans_reader #(.RD_LAT(2)) dut_lat2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start2),
        .busy    (busy2),
        .done    (done2),
        .rd_en   (rd_en2),
        .raddr   (raddr2),
        .rd_data (rd_data2),
        .m_valid (m_valid2),
        .m_ready (m_ready2),
        .m_data  (m_data2),
        .m_last  (m_last2),
        .m_eot   (m_eot2)
    );

    function automatic logic [511:0] buf_word(input logic [8:0] w);
        logic [511:0] v;
        for (int k = 0; k < 8; k++) begin
            v[64*k +: 64] = 64'(w) * 64'd8 + 64'(k);
        end
        return v;
    endfunction

    always @(posedge clk) begin
        rd_data   <= rd_en ? buf_word(raddr) : '0;
        rd_stage2 <= rd_en2 ? buf_word(raddr2) : '0;
        rd_data2  <= rd_stage2;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || raddr !== 9'd0 ||
            m_valid !== 1'b0 || m_data !== 64'd0 || m_last !== 1'b0 || m_eot !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b rd_en=%b raddr=%0d m_valid=%b m_data=%0d m_last=%b m_eot=%b, all must be 0",
                     tag, busy, done, rd_en, raddr, m_valid, m_data, m_last, m_eot);
        end
    endtask

    // One full pass on the RD_LAT=1 instance. mode: 0 ready high, 1 random ready,
    // 2 ready dropped for 20 cycles when element 7 is presented.
    task automatic run_pass(input int mode, input int poke_at, input bit poke_on_done,
                            input int rst_at, input string tag);
        int          e;
        int          cyc;
        int          reads;
        int          first_valid;
        int          last_hs;
        int          stall_left;
        int          max_ahead;
        int          gaps;
        bit          stall_used;
        bit          stalled_prev;
        bit          finished;
        bit          was_reset;
        logic [63:0] hold_d;
        logic        hold_l;
        logic        hold_t;
        logic        exp_l;
        logic        exp_t;

        e = 0; reads = 0; first_valid = -1; last_hs = -1; stall_left = 0;
        max_ahead = 0; gaps = 0; stall_used = 0; stalled_prev = 0;
        finished = 0; was_reset = 0;
        hold_d = '0; hold_l = 0; hold_t = 0;

        start = 1'b1;
        m_ready = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;

        checks++;
        if (busy !== 1'b1 || rd_en !== 1'b1 || raddr !== 9'd0) begin
            errors++;
            $display("FAIL %s first_cycle: busy=%b rd_en=%b raddr=%0d, need 1 1 0", tag, busy, rd_en, raddr);
        end

        while (!finished && cyc < TB_BUDGET) begin
            if (stalled_prev) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== hold_d || m_last !== hold_l || m_eot !== hold_t) begin
                    errors++;
                    $display("FAIL %s hold_stable: valid=%b data=%0d last=%b eot=%b, need 1 %0d %b %b",
                             tag, m_valid, m_data, m_last, m_eot, hold_d, hold_l, hold_t);
                end
            end

            if (rd_en === 1'b1) begin
                checks++;
                if (raddr !== 9'(reads)) begin
                    errors++;
                    $display("FAIL %s raddr_seq: got %0d, need %0d", tag, raddr, reads);
                end
                reads++;
            end
            if (reads - e / 8 > max_ahead) max_ahead = reads - e / 8;

            if (done === 1'b1) begin
                checks++;
                if (e != TB_NE || cyc != last_hs + 1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_timing: elems=%0d cyc=%0d last_hs=%0d busy=%b, need %0d elems, cyc=last_hs+1, busy 0",
                             tag, e, cyc, last_hs, busy, TB_NE);
                end
                finished = 1;
                if (poke_on_done) start = 1'b1;
            end

            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (e == 7 && m_valid === 1'b1 && !stall_used) begin
                        stall_left = 20;
                        stall_used = 1;
                    end
                    m_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
            endcase

            if (m_valid === 1'b1) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    checks++;
                    if (cyc != 3) begin
                        errors++;
                        $display("FAIL %s first_valid_latency: got cycle %0d, need 3", tag, cyc);
                    end
                end
                if (m_ready) begin
                    exp_l = ((e % TB_MROW) == TB_MROW - 1);
                    exp_t = (e == TB_NE - 1);
                    checks++;
                    if (m_data !== 64'(e) || m_last !== exp_l || m_eot !== exp_t) begin
                        errors++;
                        $display("FAIL %s element: data=%0d last=%b eot=%b, need %0d %b %b",
                                 tag, m_data, m_last, m_eot, e, exp_l, exp_t);
                    end
                    if (e == poke_at) start = 1'b1;
                    if (e == rst_at) rst_n = 1'b0;
                    last_hs = cyc;
                    e++;
                end
            end else if (mode == 0 && first_valid >= 0 && e < TB_NE) begin
                gaps++;
            end

            stalled_prev = (m_valid === 1'b1) && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
            hold_t = m_eot;

            step();
            start = 1'b0;
            cyc++;

            if (rst_n === 1'b0) begin
                rst_n = 1'b1;
                check_idle_outputs({tag, " after_reset"});
                finished = 1;
                was_reset = 1;
            end
        end

        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d elements after %0d cycles, need %0d", tag, e, cyc, TB_NE);
        end
        if (mode == 0 && !was_reset) begin
            checks++;
            if (gaps != 0) begin
                errors++;
                $display("FAIL %s gap_free: %0d bubbles, need 0", tag, gaps);
            end
        end
        if (mode == 2) begin
            checks++;
            if (max_ahead > 2 || e != TB_NE) begin
                errors++;
                $display("FAIL %s stall_window: max reads ahead %0d elems %0d, need <=2 and %0d", tag, max_ahead, e, TB_NE);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        m_ready = 1'b1;
        start2 = 1'b0;
        m_ready2 = 1'b1;
        step();
        step();
        check_idle_outputs("reset_asserted");
        rst_n = 1'b1;
        step();
        step();
        check_idle_outputs("reset_released");
    endtask

    task automatic test_stream();
        run_pass(0, -1, 1'b0, -1, "stream");
        step();
        check_idle_outputs("stream_idle_after");
    endtask

    task automatic test_random_ready();
        run_pass(1, -1, 1'b0, -1, "random_ready");
        step();
    endtask

    task automatic test_stall();
        run_pass(2, -1, 1'b0, -1, "stall20");
        step();
    endtask

    task automatic test_ignored_start();
        run_pass(0, 100, 1'b1, -1, "start_ignored");
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL start_ignored idle_%0d: busy=%b rd_en=%b m_valid=%b, need 0 0 0", i, busy, rd_en, m_valid);
            end
            step();
        end
        run_pass(0, -1, 1'b0, -1, "replay");
        step();
    endtask

    task automatic test_mid_reset();
        run_pass(0, -1, 1'b0, 1000, "mid_reset");
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle_outputs("mid_reset_quiet");
        end
        run_pass(0, -1, 1'b0, -1, "after_reset");
        step();
    endtask

    task automatic test_rd_lat2();
        int e;
        int cyc;
        int first_valid;
        int gaps;
        bit finished;

        e = 0; first_valid = -1; gaps = 0; finished = 0;
        m_ready2 = 1'b1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        cyc = 1;
        while (!finished && cyc < TB_BUDGET) begin
            if (done2 === 1'b1) begin
                finished = 1;
                checks++;
                if (e != TB_NE || busy2 !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_lat2 done: elems=%0d busy=%b, need %0d 0", e, busy2, TB_NE);
                end
            end
            if (m_valid2 === 1'b1) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    checks++;
                    if (cyc != 4) begin
                        errors++;
                        $display("FAIL rd_lat2 first_valid_latency: got cycle %0d, need 4", cyc);
                    end
                end
                checks++;
                if (m_data2 !== 64'(e) || m_eot2 !== (e == TB_NE - 1)) begin
                    errors++;
                    $display("FAIL rd_lat2 element: data=%0d eot=%b, need %0d %b", m_data2, m_eot2, e, (e == TB_NE - 1));
                end
                e++;
            end else if (first_valid >= 0 && e < TB_NE) begin
                gaps++;
            end
            step();
            cyc++;
        end
        checks++;
        if (!finished || gaps != 0) begin
            errors++;
            $display("FAIL rd_lat2 stream: finished=%0d bubbles=%0d elems=%0d, need 1 0 %0d", finished, gaps, e, TB_NE);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_random_ready();
        test_stall();
        test_ignored_start();
        test_mid_reset();
        test_rd_lat2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
